// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// One quotient bit is produced per cycle. The result is {remainder, quotient} and is held while ready_o is high.
module div_seq #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  busy_o
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  localparam logic [1:0] S_FREE   = 2'd0;
  localparam logic [1:0] S_BYZERO = 2'd1;
  localparam logic [1:0] S_ON     = 2'd2;
  localparam logic [1:0] S_END    = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_W-1:0]     dvd_q, dvd_d;
  logic [DATA_W-1:0]     dsr_q, dsr_d;
  logic [DATA_W-1:0]     rem_q, rem_d;
  logic                  negq_q, negq_d;
  logic                  negr_q, negr_d;
  logic                  armed_q, armed_d;
  logic [2*DATA_W-1:0]   result_q, result_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;

  logic [DATA_W-1:0]     op1_abs, op2_abs;
  logic [DATA_W:0]       trial;
  logic                  ge;

  assign op1_abs = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign op2_abs = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

  // dvd_q feeds dividend bits out of its MSB and collects quotient bits at its LSB.
  assign trial = {rem_q, dvd_q[DATA_W-1]};
  assign ge    = (trial >= {1'b0, dsr_q});

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dsr_d    = dsr_q;
    rem_d    = rem_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    armed_d  = armed_q;
    result_d = result_q;

    case (state_q)
      S_FREE: begin
        // A new request is taken only after start_i was seen low in FREE.
        if (!start_i) armed_d = 1'b1;
        if (start_i && !annul_i && armed_q) begin
          armed_d = 1'b0;
          if (opdata2_i == '0) begin
            state_d = S_BYZERO;
          end else begin
            state_d = S_ON;
            dvd_d   = op1_abs;
            dsr_d   = op2_abs;
            rem_d   = '0;
            cnt_d   = '0;
            negq_d  = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
            negr_d  = signed_div_i & opdata1_i[DATA_W-1];
          end
        end
      end
      S_BYZERO: begin
        state_d  = S_END;
        result_d = '0;
      end
      S_ON: begin
        if (cnt_q == CNT_W'(DATA_W)) begin
          state_d  = S_END;
          result_d = {negr_q ? -rem_q : rem_q, negq_q ? -dvd_q : dvd_q};
        end else begin
          // The difference is below the divisor, so it fits in DATA_W bits.
          rem_d = ge ? (trial[DATA_W-1:0] - dsr_q) : trial[DATA_W-1:0];
          dvd_d = {dvd_q[DATA_W-2:0], ge};
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (!start_i) begin
          state_d  = S_FREE;
          result_d = '0;
        end
      end
    endcase

    if (annul_i && state_q != S_FREE) begin
      state_d  = S_FREE;
      result_d = '0;
      armed_d  = 1'b0;
    end
  end

  assign busy_d  = (state_d == S_BYZERO) || (state_d == S_ON);
  assign ready_d = (state_d == S_END);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_FREE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dsr_q    <= '0;
      rem_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      armed_q  <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dsr_q    <= dsr_d;
      rem_q    <= rem_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      armed_q  <= armed_d;
      result_q <= result_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign busy_o   = busy_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: each vector has a hand-computed result, latency and busy window.
module tb_div_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div, start, annul;
  logic [31:0] op1, op2;
  logic [63:0] result;
  logic        ready, busy;

  int n_cmp = 0;
  int n_bad = 0;

  div_seq #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div), .opdata1_i(op1), .opdata2_i(op2),
    .start_i(start), .annul_i(annul), .result_o(result), .ready_o(ready), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one request, then count the edges until ready (including the accepting edge E0).
  task automatic run_op(input string tag, input logic sd, input logic [31:0] a, input logic [31:0] b,
                        input int exp_lat, input logic [63:0] exp_res);
    int n, nb;
    signed_div = sd; op1 = a; op2 = b; start = 1'b1;
    n = 0; nb = 0;
    do begin
      step();
      n++;
      if (busy) nb++;
    end while (!ready && n < 100);
    chk({tag, "_lat"}, 64'(n - 1), 64'(exp_lat));
    chk({tag, "_busy"}, 64'(nb), 64'(exp_lat));
    chk({tag, "_res"}, result, exp_res);
  endtask

  task automatic release_op(input string tag);
    start = 1'b0;
    step();
    chk({tag, "_rel"}, {ready, busy, result}, 66'h0);
    step();
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; annul = 1'b0; signed_div = 1'b0; op1 = '0; op2 = '0;
    #12;
    chk("rst_out", {ready, busy, result}, 66'h0);
    @(posedge clk); #1; rst = 1'b1;
    step(); step();

    run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 33, {32'd2, 32'd14});
    release_op("divu_100_7");

    run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    release_op("div_m7_2");

    run_op("div_by0", 1'b1, 32'd7, 32'd0, 1, 64'h0);
    release_op("div_by0");

    run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, {32'h0, 32'h8000_0000});
    release_op("div_ovf");

    run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33, {32'd1, 32'hFFFF_FFFD});
    release_op("div_7_m2");

    run_op("divu_big", 1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 33, {32'h7FFF_FFFF, 32'd1});
    release_op("divu_big");

    // Annul at iteration 10
    signed_div = 1'b0; op1 = 32'hFFFF_FFFF; op2 = 32'd3; start = 1'b1;
    step();
    for (int i = 0; i < 10; i++) step();
    chk("ann_busy_pre", 64'(busy), 64'd1);
    annul = 1'b1;
    step();
    chk("ann_free", {ready, busy, result}, 66'h0);
    annul = 1'b0; start = 1'b0;
    step();
    run_op("divu_9_3", 1'b0, 32'd9, 32'd3, 33, {32'd0, 32'd3});
    release_op("divu_9_3");

    // Asynchronous reset at iteration 20
    signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
    step();
    for (int i = 0; i < 20; i++) step();
    rst = 1'b0;
    #1;
    chk("arst_out", {ready, busy, result}, 66'h0);
    start = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    step(); step();
    run_op("divu_50_5", 1'b0, 32'd50, 32'd5, 33, {32'd0, 32'd10});

    // start held high in END keeps the result steady
    for (int i = 0; i < 4; i++) step();
    chk("hold_end", {ready, busy, result}, {2'b10, 32'd0, 32'd10});
    start = 1'b0;
    step();
    chk("hold_rel", {ready, busy, result}, 66'h0);
    step();

    // Annul out of END with start still high: no re-accept until start drops
    run_op("divu_20_6", 1'b0, 32'd20, 32'd6, 33, {32'd2, 32'd3});
    annul = 1'b1;
    step();
    annul = 1'b0;
    chk("end_annul", {ready, busy}, 2'b00);
    for (int i = 0; i < 3; i++) step();
    chk("no_reaccept", {ready, busy}, 2'b00);
    start = 1'b0;
    step();
    run_op("divu_21_4", 1'b0, 32'd21, 32'd4, 33, {32'd1, 32'd5});
    release_op("divu_21_4");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
